// File: rtl/sm4_round_engine_pkg.sv
// Shared SM4 constants, FSM state encoding and S-box.
// Also used by the key-expansion block.
package sm4_round_engine_pkg;

  localparam int SM4_ROUNDS  = 32;
  localparam int SM4_BLOCK_W = 128;
  localparam int SM4_WORD_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sm4_state_e;

  // Element 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SM4_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

endpackage

// File: rtl/sm4_round_engine_transform.sv
// Combinational SM4 round transform T = L(tau(x)) for the data path.
module transform_for_encdec
  import sm4_round_engine_pkg::*;
(
  input  logic [SM4_WORD_W-1:0] x_i,
  output logic [SM4_WORD_W-1:0] y_o
);

  logic [SM4_WORD_W-1:0] b;

  always_comb begin
    b = '0;
    for (int i = 0; i < 4; i++) begin
      b[8*i +: 8] = SM4_SBOX[x_i[8*i +: 8]];
    end
  end

  // Linear diffusion: b ^ b<<<2 ^ b<<<10 ^ b<<<18 ^ b<<<24
  assign y_o = b
             ^ {b[29:0], b[31:30]}
             ^ {b[21:0], b[31:22]}
             ^ {b[13:0], b[31:14]}
             ^ {b[7:0],  b[31:8]};

endmodule

// File: rtl/sm4_round_engine.sv
// Iterative SM4 encrypt/decrypt engine: one round per clock on the X0..X3 state,
// round keys fetched combinationally from the external key store via rk_addr.
module sm4_round_engine
  import sm4_round_engine_pkg::*;
#(
  parameter int ROUNDS = SM4_ROUNDS,
  parameter int CNT_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   decrypt,
  input  logic [SM4_BLOCK_W-1:0] data_in,
  input  logic                   rk_valid,
  output logic [CNT_W-1:0]       rk_addr,
  input  logic [SM4_WORD_W-1:0]  rk_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SM4_BLOCK_W-1:0] data_out,
  output sm4_state_e             dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  sm4_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dec_q, dec_d;
  logic [SM4_WORD_W-1:0] x0_q, x1_q, x2_q, x3_q;
  logic [SM4_WORD_W-1:0] x0_d, x1_d, x2_d, x3_d;
  logic [SM4_BLOCK_W-1:0] dout_q, dout_d;
  logic [SM4_WORD_W-1:0] t_in, t_out, x_new;

  assign t_in  = x1_q ^ x2_q ^ x3_q ^ rk_data;
  assign x_new = x0_q ^ t_out;

  transform_for_encdec u_t (
    .x_i (t_in),
    .y_o (t_out)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and ready never depends on valid.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dec_d     = dec_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    x3_d      = x3_q;
    dout_d    = dout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = rk_valid;
        if (in_valid && rk_valid) begin
          {x0_d, x1_d, x2_d, x3_d} = data_in;
          dec_d   = decrypt;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        {x0_d, x1_d, x2_d, x3_d} = {x1_q, x2_q, x3_q, x_new};
        if (cnt_q == LAST_CNT) begin
          // Output is the word-reversed final state {X35,X34,X33,X32}.
          dout_d  = {x_new, x3_q, x2_q, x1_q};
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      x3_q    <= x3_d;
      dout_q  <= dout_d;
    end
  end

  // Decryption walks the same schedule backwards.
  assign rk_addr   = dec_q ? (LAST_CNT - cnt_q) : cnt_q;
  assign data_out  = dout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sm4_round_engine.sv
// Directed and randomized checks of sm4_round_engine against a block-level SM4 model.
module tb_sm4_round_engine;
  import sm4_round_engine_pkg::*;

  localparam int ROUNDS = 32;
  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [0:255][7:0] TB_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, decrypt, rk_valid, out_valid, out_ready;
  logic [127:0] data_in, data_out;
  logic [4:0]   rk_addr;
  logic [31:0]  rk_data;
  sm4_state_e   dbg_state;

  always #5 clk = ~clk;

  logic [31:0] rk_mem [32];
  assign rk_data = rk_mem[rk_addr];

  sm4_round_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .decrypt   (decrypt),
    .data_in   (data_in),
    .rk_valid  (rk_valid),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] a, input int n);
    return (a << n) | (a >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = TB_SBOX[a[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0]  k [36];
    logic [127:0] fk;
    logic [31:0]  ck;
    fk = 128'ha3b1bac656aa3350677d9197b27022dc;
    for (int i = 0; i < 4; i++) k[i] = key[127-32*i -: 32] ^ fk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'(((4*i + j) * 7) % 256)};
      k[i+4]    = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      rk_mem[i] = k[i+4];
    end
  endtask

  function automatic logic [127:0] sm4_model(input logic [127:0] din, input logic dec);
    logic [31:0] x [36];
    for (int i = 0; i < 4; i++) x[i] = din[127-32*i -: 32];
    for (int i = 0; i < 32; i++)
      x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk_mem[dec ? 31 - i : i]);
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_block(input logic [127:0] din, input logic dec);
    logic got;
    got = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = din;
    decrypt  = dec;
    exp_q.push_back(sm4_model(din, dec));
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", 128'(got), 128'd1);
    if (got) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic dec, output logic [31:0] first_rk);
    logic seq_ok;
    int   nrun;
    seq_ok   = 1'b1;
    nrun     = 0;
    first_rk = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (nrun == 0) first_rk = rk_data;
      if (rk_addr !== (dec ? 5'(31 - nrun) : 5'(nrun))) seq_ok = 1'b0;
      nrun++;
    end
    check("latency", 128'(nrun), 128'(ROUNDS));
    check("rk_addr_seq", 128'(seq_ok), 128'd1);
    check("out_valid_high", 128'(out_valid), 128'd1);
  endtask

  task automatic finish_block(input int hold);
    logic [127:0] held, exp;
    logic         stable;
    held   = data_out;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!out_valid || data_out !== held || in_ready) stable = 1'b0;
    end
    check("hold_stable", 128'(stable), 128'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check("data_out", data_out, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drop", 128'(out_valid), 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0]  frk;
    logic [127:0] held, nxt, v;
    logic         ok, dec;

    rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; data_in = '0;
    rk_valid = 1'b0; out_ready = 1'b0;
    load_key(KEY);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_data_out", data_out, 128'd0);
    check("rst_rk_addr", 128'(rk_addr), 128'd0);
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("no_rk_in_ready", 128'(in_ready), 128'd0);
    rk_valid = 1'b1;
    #1;
    check("rk_in_ready", 128'(in_ready), 128'd1);

    // Known-answer encrypt and decrypt
    start_block(PT, 1'b0);
    wait_done(1'b0, frk);
    check("rk0", 128'(frk), 128'h f12186f9);
    check("kat_enc", data_out, CT);
    finish_block(0);
    start_block(CT, 1'b1);
    wait_done(1'b1, frk);
    check("rk31", 128'(frk), 128'h9124a012);
    check("kat_dec", data_out, PT);
    finish_block(2);

    // Backpressure with a pending block that must wait for IDLE
    start_block(PT, 1'b0);
    wait_done(1'b0, frk);
    held = data_out;
    nxt  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; data_in = nxt; decrypt = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || data_out !== held || in_ready || dbg_state !== ST_DONE) ok = 1'b0;
    end
    check("bp_stable", 128'(ok), 128'd1);
    check("bp_data", data_out, exp_q.pop_front());
    exp_q.push_back(sm4_model(nxt, 1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", 128'(dbg_state), 128'(ST_RUN));
    wait_done(1'b0, frk);
    finish_block(1);

    // Key store not ready: request held off until rk_valid rises
    held = data_out;
    rk_valid = 1'b0;
    nxt = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b1; data_in = nxt; decrypt = 1'b1;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (in_ready || dbg_state !== ST_IDLE) ok = 1'b0;
    end
    check("rk_wait_no_accept", 128'(ok), 128'd1);
    check("data_out_held_idle", data_out, held);
    rk_valid = 1'b1;
    #1;
    check("rk_wait_ready", 128'(in_ready), 128'd1);
    exp_q.push_back(sm4_model(nxt, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rk_wait_accepted", 128'(dbg_state), 128'(ST_RUN));
    wait_done(1'b1, frk);
    finish_block(0);

    // Asynchronous reset in the middle of a decrypt
    start_block(CT, 1'b1);
    repeat (16) @(negedge clk);
    check("mid_state", 128'(dbg_state), 128'(ST_RUN));
    rst = 1'b1;
    #1;
    check("arst_state", 128'(dbg_state), 128'(ST_IDLE));
    check("arst_out_valid", 128'(out_valid), 128'd0);
    check("arst_data_out", data_out, 128'd0);
    check("arst_rk_addr", 128'(rk_addr), 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    check("arst_no_pulse", 128'(ok), 128'd1);
    start_block(PT, 1'b0);
    wait_done(1'b0, frk);
    check("post_rst_enc", data_out, CT);
    finish_block(0);

    // Chained encryptions
    v = PT;
    for (int i = 0; i < 8; i++) begin
      start_block(v, 1'b0);
      wait_done(1'b0, frk);
      finish_block($urandom_range(0, 2));
      v = sm4_model(v, 1'b0);
    end

    // Random keys, modes and data
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rk_valid = 1'b0;
      load_key({$urandom, $urandom, $urandom, $urandom});
      @(negedge clk);
      rk_valid = 1'b1;
      for (int b = 0; b < 3; b++) begin
        dec = 1'($urandom_range(0, 1));
        start_block({$urandom, $urandom, $urandom, $urandom}, dec);
        wait_done(dec, frk);
        finish_block($urandom_range(0, 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
